// File: rtl/dmem_lsu.sv
// MEM-stage load/store unit: valid/ready request plus response on a data bus.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module dmem_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall_mem,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misalign_err,
  output logic        bus_timeout,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] ld_q, ld_d;
  logic        to_q, to_d;

  logic        is_byte, is_half;
  logic [3:0]  wstrb_c;
  logic [31:0] wdata_c;
  logic        trap_c;
  logic [63:0] rot_c;
  logic [31:0] ld_ext;

  assign is_byte = (funct3[1:0] == 2'b00);
  assign is_half = (funct3[1:0] == 2'b01);

  always_comb begin
    wstrb_c = 4'b1111;
    wdata_c = wdata;
    unique case (1'b1)
      is_byte: begin
        wstrb_c = 4'b0001 << addr[1:0];
        wdata_c = {4{wdata[7:0]}};
      end
      is_half: begin
        wstrb_c = 4'b0011 << {addr[1], 1'b0};
        wdata_c = {2{wdata[15:0]}};
      end
      default: begin
        wstrb_c = 4'b1111;
        wdata_c = wdata;
      end
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned_c;
  assign misaligned_c = (is_half & addr[0]) |
                        (!is_byte & !is_half & (|addr[1:0]));
  assign trap_c = (state_q == IDLE) & req_valid & misaligned_c;
  assign misalign_err = reset & trap_c;
`else
  assign trap_c = 1'b0;
  assign misalign_err = 1'b0;
`endif

  // Rotate so that misaligned halves wrap within the word.
  assign rot_c = {bus_rdata, bus_rdata} >> {lane_q, 3'b000};

  always_comb begin
    ld_ext = bus_rdata;
    unique case (f3_q[1:0])
      2'b00: ld_ext = {{24{~f3_q[2] & rot_c[7]}}, rot_c[7:0]};
      2'b01: ld_ext = {{16{~f3_q[2] & rot_c[15]}}, rot_c[15:0]};
      default: ld_ext = bus_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    lane_d  = lane_q;
    ld_d    = ld_q;
    to_d    = to_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid && !trap_c) begin
          state_d = REQ;
          we_d    = mem_write;
          addr_d  = {addr[31:2], 2'b00};
          wstrb_d = mem_write ? wstrb_c : 4'b0000;
          wdata_d = wdata_c;
          f3_d    = funct3;
          lane_d  = addr[1:0];
        end
      end
      REQ: begin
        if (bus_req_ready) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (bus_rsp_valid) begin
          state_d = DONE;
          to_d    = 1'b0;
          if (!we_q) ld_d = ld_ext;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == TO_MAX) begin
            state_d = DONE;
            to_d    = 1'b1;
            ld_d    = '0;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      lane_q  <= '0;
      ld_q    <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      lane_q  <= lane_d;
      ld_q    <= ld_d;
      to_q    <= to_d;
    end
  end

  assign stall_mem = reset & (
    ((state_q == IDLE) & req_valid & !trap_c) |
    (state_q == REQ) | (state_q == WAIT));
  assign done          = reset & (state_q == DONE);
  assign bus_timeout   = reset & (state_q == DONE) & to_q;
  assign bus_req_valid = reset & (state_q == REQ);
  assign bus_we        = we_q;
  assign bus_addr      = addr_q;
  assign bus_wstrb     = wstrb_q;
  assign bus_wdata     = wdata_q;
  assign load_data     = ld_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed self-checking bench for dmem_lsu (TIMEOUT=4).
// Misalign expectations follow LSU_MISALIGN_TRAP_EN.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall_mem, done, misalign_err, bus_timeout;
  logic [31:0] load_data;
  logic        bus_req_valid, bus_req_ready, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;
  logic        bus_rsp_valid;

  int errs = 0;
  int checks = 0;

  int          r_stall, r_done, r_post_stall;
  logic [31:0] r_ld, r_addr, r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_to, r_we;

  dmem_lsu #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .wdata(wdata),
    .stall_mem(stall_mem), .done(done),
    .load_data(load_data), .misalign_err(misalign_err),
    .bus_timeout(bus_timeout),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One access with given bus latencies; rsp_lat < 0 means no response.
  task automatic access(input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int rdy_lat,
                        input int rsp_lat, input logic late_rsp);
    int reqc, waitc;
    logic in_wait;
    reqc = 0; waitc = 0; in_wait = 1'b0;
    r_stall = 0; r_done = 0; r_post_stall = 0;
    r_ld = '0; r_to = 1'b0;
    req_valid = 1'b1; mem_write = we; funct3 = f3;
    addr = a; wdata = wd;
    for (int cyc = 0; cyc < 60 && r_done == 0; cyc++) begin
      bus_req_ready = 1'b0;
      bus_rsp_valid = 1'b0;
      bus_rdata = rd;
      if (in_wait) begin
        bus_rsp_valid = (rsp_lat >= 0) && (waitc == rsp_lat);
        waitc++;
      end else if (bus_req_valid) begin
        r_addr = bus_addr; r_wstrb = bus_wstrb;
        r_wdata = bus_wdata; r_we = bus_we;
        bus_req_ready = (reqc >= rdy_lat);
        in_wait = bus_req_ready;
        reqc++;
      end
      #1;
      if (stall_mem) r_stall++;
      if (done) begin
        r_done++;
        r_ld = load_data;
        r_to = bus_timeout;
      end
      @(posedge clk);
      #1;
    end
    if (r_done == 0) chk("no_done_watchdog", 32'd0, 32'd1);
    req_valid = 1'b0;
    bus_req_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus_rsp_valid = late_rsp;
      #1;
      if (done) r_done++;
      if (stall_mem) r_post_stall++;
      step();
    end
    bus_rsp_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; mem_write = 1'b0;
    funct3 = 3'b010; addr = '0; wdata = '0;
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = '0;
    step(); step();
    chk("rst_stall", {31'd0, stall_mem}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_reqv", {31'd0, bus_req_valid}, 32'd0);
    chk("rst_ld", load_data, 32'd0);
    chk("rst_wstrb", {28'd0, bus_wstrb}, 32'd0);
    chk("rst_to", {31'd0, bus_timeout}, 32'd0);
    chk("rst_mis", {31'd0, misalign_err}, 32'd0);
    reset = 1'b1;
    step();
    chk("idle_stall", {31'd0, stall_mem}, 32'd0);

    access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 1'b0);
    chk("lw_ld", r_ld, 32'hDEADBEEF);
    chk("lw_stall", r_stall, 3);
    chk("lw_addr", r_addr, 32'h100);
    chk("lw_done", r_done, 1);
    chk("lw_wstrb", {28'd0, r_wstrb}, 32'd0);
    chk("lw_to", {31'd0, r_to}, 32'd0);

    access(1'b0, 3'b000, 32'h203, 32'h0, 32'h80FF0000, 0, 0, 1'b0);
    chk("lb_ld", r_ld, 32'hFFFFFF80);
    chk("lb_addr", r_addr, 32'h200);
    access(1'b0, 3'b100, 32'h203, 32'h0, 32'h80FF0000, 0, 0, 1'b0);
    chk("lbu_ld", r_ld, 32'h00000080);
    access(1'b0, 3'b001, 32'h202, 32'h0, 32'h80FF0000, 0, 0, 1'b0);
    chk("lh_ld", r_ld, 32'hFFFF80FF);
    access(1'b0, 3'b101, 32'h202, 32'h0, 32'h80FF0000, 0, 0, 1'b0);
    chk("lhu_ld", r_ld, 32'h000080FF);

    access(1'b1, 3'b001, 32'h302, 32'h1234ABCD, 32'h0, 0, 2, 1'b0);
    chk("sh_wstrb", {28'd0, r_wstrb}, 32'hC);
    chk("sh_wdata", r_wdata, 32'hABCDABCD);
    chk("sh_we", {31'd0, r_we}, 32'd1);
    chk("sh_addr", r_addr, 32'h300);
    chk("sh_stall", r_stall, 5);
    access(1'b1, 3'b000, 32'h301, 32'h1234ABCD, 32'h0, 0, 0, 1'b0);
    chk("sb_wstrb", {28'd0, r_wstrb}, 32'h2);
    chk("sb_wdata", r_wdata, 32'hCDCDCDCD);

    access(1'b0, 3'b010, 32'h500, 32'h0, 32'h11223344, 5, 3, 1'b0);
    chk("bp_stall", r_stall, 11);
    chk("bp_done", r_done, 1);
    chk("bp_ld", r_ld, 32'h11223344);
    chk("bp_post", r_post_stall, 0);

    access(1'b0, 3'b010, 32'h600, 32'h0, 32'hCAFEF00D, 0, -1, 1'b1);
    chk("to_stall", r_stall, 6);
    chk("to_flag", {31'd0, r_to}, 32'd1);
    chk("to_ld", r_ld, 32'd0);
    chk("to_done", r_done, 1);
    chk("to_late_ld", load_data, 32'd0);

    req_valid = 1'b1; mem_write = 1'b0;
    funct3 = 3'b010; addr = 32'h101;
    #1;
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_err", {31'd0, misalign_err}, 32'd1);
    chk("mis_stall", {31'd0, stall_mem}, 32'd0);
    step();
    chk("mis_noreq", {31'd0, bus_req_valid}, 32'd0);
    req_valid = 1'b0;
    step();
`else
    chk("mis_err", {31'd0, misalign_err}, 32'd0);
    chk("mis_stall", {31'd0, stall_mem}, 32'd1);
    access(1'b0, 3'b010, 32'h101, 32'h0, 32'hAABBCCDD, 0, 0, 1'b0);
    chk("mis_ld", r_ld, 32'hAABBCCDD);
    chk("mis_addr", r_addr, 32'h100);
`endif

    access(1'b0, 3'b010, 32'h700, 32'h0, 32'h5A5A5A5A, 0, 0, 1'b0);
    chk("pre_rst_ld", r_ld, 32'h5A5A5A5A);
    req_valid = 1'b1; mem_write = 1'b1;
    funct3 = 3'b010; addr = 32'h404; wdata = 32'h9;
    step();
    bus_req_ready = 1'b1;
    step();
    bus_req_ready = 1'b0;
    chk("mid_stall", {31'd0, stall_mem}, 32'd1);
    reset = 1'b0;
    step();
    chk("mr_stall", {31'd0, stall_mem}, 32'd0);
    chk("mr_done", {31'd0, done}, 32'd0);
    chk("mr_reqv", {31'd0, bus_req_valid}, 32'd0);
    chk("mr_ld", load_data, 32'd0);
    chk("mr_addr", bus_addr, 32'd0);
    chk("mr_we", {31'd0, bus_we}, 32'd0);
    chk("mr_wstrb", {28'd0, bus_wstrb}, 32'd0);
    reset = 1'b1; req_valid = 1'b0;
    bus_rsp_valid = 1'b1; bus_rdata = 32'hFFFFFFFF;
    step();
    chk("late_done", {31'd0, done}, 32'd0);
    bus_rsp_valid = 1'b0;
    step();
    chk("late_done2", {31'd0, done}, 32'd0);
    chk("late_ld", load_data, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
